// File: rtl/mem_wb_stage_pkg.sv
// Shared encodings and bus widths for the MEM and WB stages.
// EX, MEM and WB all import this so load-op codes stay identical.
package mem_wb_stage_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;

    localparam logic [RegBus-1:0] ZeroWord = '0;

    typedef enum logic [2:0] {
        LOAD_NONE = 3'd0,
        LOAD_LB   = 3'd1,
        LOAD_LBU  = 3'd2,
        LOAD_LH   = 3'd3,
        LOAD_LHU  = 3'd4,
        LOAD_LW   = 3'd5
    } load_op_e;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Load data alignment and extension for the write-back path.
// Also reports halfword/word accesses that are not naturally aligned.
module load_align
    import mem_wb_stage_pkg::*;
(
    input  logic [2:0]        load_op,
    input  logic [1:0]        addr_low,
    input  logic [RegBus-1:0] rdata,
    input  logic [RegBus-1:0] wdata,
    output logic [RegBus-1:0] data,
    output logic              misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/half, then extend according to the load kind
    always_comb begin
        byte_sel   = rdata[{addr_low, 3'b000} +: 8];
        half_sel   = addr_low[1] ? rdata[31:16] : rdata[15:0];
        data       = wdata;
        misaligned = 1'b0;
        case (load_op)
            LOAD_LB:  data = {{24{byte_sel[7]}}, byte_sel};
            LOAD_LBU: data = {24'h0, byte_sel};
            LOAD_LH: begin
                data       = {{16{half_sel[15]}}, half_sel};
                misaligned = addr_low[0];
            end
            LOAD_LHU: begin
                data       = {16'h0, half_sel};
                misaligned = addr_low[0];
            end
            LOAD_LW: begin
                data       = rdata;
                misaligned = (addr_low != 2'b00);
            end
            default:  data = wdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register driving the register-file write port.
// Handles flush/stall priority, misaligned-load squash and retire count.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_mem,
    input  logic                  stall_wb,
    input  logic                  flush,
    input  logic                  mem_valid,
    input  logic                  mem_wreg,
    input  logic [RegAddrBus-1:0] mem_wd,
    input  logic [RegBus-1:0]     mem_wdata,
    input  logic [2:0]            mem_load_op,
    input  logic [1:0]            mem_addr_low,
    input  logic [RegBus-1:0]     mem_rdata,
    output logic                  wb_wreg,
    output logic [RegAddrBus-1:0] wb_wd,
    output logic [RegBus-1:0]     wb_wdata,
    output logic                  wb_valid,
    output logic                  load_misalign,
    output logic [CNT_W-1:0]      retire_cnt
);

    logic [RegBus-1:0] align_data;
    logic              align_mis;

    logic                  wreg_q, wreg_d;
    logic [RegAddrBus-1:0] wd_q, wd_d;
    logic [RegBus-1:0]     wdata_q, wdata_d;
    logic                  valid_q, valid_d;
    logic                  mis_q, mis_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic bubble;

    load_align u_load_align (
        .load_op    (mem_load_op),
        .addr_low   (mem_addr_low),
        .rdata      (mem_rdata),
        .wdata      (mem_wdata),
        .data       (align_data),
        .misaligned (align_mis)
    );

    // A stalled MEM feeding a free WB leaves a hole; flush wins over all
    assign bubble = flush | (stall_mem & ~stall_wb);

    // Next-state selection: bubble, hold or capture
    always_comb begin
        wreg_d  = wreg_q;
        wd_d    = wd_q;
        wdata_d = wdata_q;
        valid_d = valid_q;
        mis_d   = 1'b0;
        cnt_d   = cnt_q;
        if (bubble) begin
            wreg_d  = 1'b0;
            wd_d    = '0;
            wdata_d = ZeroWord;
            valid_d = 1'b0;
        end else if (!stall_wb) begin
            wreg_d  = mem_valid & mem_wreg
                    & (mem_wd != '0) & ~align_mis;
            wd_d    = mem_wd;
            wdata_d = align_mis ? ZeroWord : align_data;
            valid_d = mem_valid;
            mis_d   = mem_valid & align_mis;
            if (mem_valid) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // WB register and retire counter, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wreg_q  <= 1'b0;
            wd_q    <= '0;
            wdata_q <= ZeroWord;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            wreg_q  <= wreg_d;
            wd_q    <= wd_d;
            wdata_q <= wdata_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wb_wreg       = wreg_q;
    assign wb_wd         = wd_q;
    assign wb_wdata      = wdata_q;
    assign wb_valid      = valid_q;
    assign load_misalign = mis_q;
    assign retire_cnt    = cnt_q;

endmodule
